// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake and data bundle for the sequential ALU.
//   master : drives go/opcode/a/b, observes result, flags, status and LEDs
//   slave  : the ALU side, inverse directions
// Signals: go, opcode[3:0], a/b[WIDTH-1:0], result[2*WIDTH-1:0],
//          cout, zero, neg, ovf, err, busy, done, led_idle, led_ready, led_done
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic               go;
    logic [3:0]         opcode;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] result;
    logic               cout;
    logic               zero;
    logic               neg;
    logic               ovf;
    logic               err;
    logic               busy;
    logic               done;
    logic               led_idle;
    logic               led_ready;
    logic               led_done;

    modport master (
        output go, opcode, a, b,
        input  result, cout, zero, neg, ovf, err,
        input  busy, done, led_idle, led_ready, led_done
    );

    modport slave (
        input  go, opcode, a, b,
        output result, cout, zero, neg, ovf, err,
        output busy, done, led_idle, led_ready, led_done
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle sequential ALU with latched operands, flags and a
// go/busy/done handshake. Single-cycle ops finish one edge after accept;
// MUL is an iterative shift-add taking WIDTH edges.
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   bus    : alu_seq_if.slave (operands/opcode in, result/flags/status out)
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    alu_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_NOTA = 4'd2;
    localparam logic [3:0] OP_NOTB = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_MUL  = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [3:0]         op_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] result_q;
    logic               cout_q, zero_q, neg_q, ovf_q, err_q;
    logic               led_idle_q, led_done_q;

    logic               accept;
    logic               mul_bit;
    logic               last_step;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout, alu_zero, alu_neg, alu_ovf, alu_err;

    logic               busy, done, led_ready;

    assign accept = (state_q == S_IDLE) && bus.go;

    // ---------------- single-cycle datapath on latched operands ----------
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = a_q - b_q;
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res  = diff;
                alu_cout = (a_q < b_q);
                alu_ovf  = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                           (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_NOTA: alu_res = ~a_q;
            OP_NOTB: alu_res = ~b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_XNOR: alu_res = ~(a_q ^ b_q);
            OP_SHL: begin
                alu_res  = a_q << 1;
                alu_cout = a_q[WIDTH-1];
            end
            OP_SHR: begin
                alu_res  = a_q >> 1;
                alu_cout = a_q[0];
            end
            OP_ASR: begin
                alu_res  = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
                alu_cout = a_q[0];
            end
            // MUL never reaches EXEC; 12..15 are illegal
            default: alu_err = 1'b1;
        endcase
        // illegal ops leave alu_res at 0, so zero comes out set for free
        alu_zero = (alu_res == '0);
        alu_neg  = alu_err ? 1'b0 : alu_res[WIDTH-1];
    end

    // ---------------- shift-add multiplier step --------------------------
    always_comb begin
        mul_bit   = |(b_q & (WIDTH'(1) << cnt_q));
        last_step = (cnt_q == CW'(WIDTH - 1));
        acc_d     = acc_q;
        if (mul_bit)
            acc_d = acc_q + ({{WIDTH{1'b0}}, a_q} << cnt_q);
    end

    // ---------------- FSM: state register ---------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state -------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.go) state_d = (bus.opcode == OP_MUL) ? S_MUL : S_EXEC;
            S_EXEC: state_d = S_DONE;
            S_MUL:  if (last_step) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        led_ready = 1'b0;
        case (state_q)
            S_IDLE:  led_ready = 1'b1;
            S_EXEC:  busy      = 1'b1;
            S_MUL:   busy      = 1'b1;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase
    end

    // ---------------- operand latch, result and flag registers ------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            led_idle_q <= 1'b1;
            led_done_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q        <= bus.a;
                b_q        <= bus.b;
                op_q       <= bus.opcode;
                acc_q      <= '0;
                cnt_q      <= '0;
                led_idle_q <= 1'b0;
                led_done_q <= 1'b0;
            end
            if (state_q == S_EXEC) begin
                result_q   <= {{WIDTH{1'b0}}, alu_res};
                cout_q     <= alu_cout;
                zero_q     <= alu_zero;
                neg_q      <= alu_neg;
                ovf_q      <= alu_ovf;
                err_q      <= alu_err;
                led_done_q <= 1'b1;
            end
            if (state_q == S_MUL) begin
                acc_q <= acc_d;
                cnt_q <= cnt_q + CW'(1);
                // final step: publish the full product as DONE is entered
                if (last_step) begin
                    result_q   <= acc_d;
                    cout_q     <= 1'b0;
                    zero_q     <= (acc_d == '0);
                    neg_q      <= 1'b0;
                    ovf_q      <= 1'b0;
                    err_q      <= 1'b0;
                    led_done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.led_idle  = led_idle_q;
    assign bus.led_ready = led_ready;
    assign bus.led_done  = led_done_q;
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0] res;
        logic        cout, zero, neg, ovf, err;
    } fl_t;

    // Reference: plain integer arithmetic on the opcode definitions.
    function automatic fl_t model(int op, int a, int b);
        fl_t m;
        int  r, sa, sb, s;
        m  = '0;
        r  = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (op)
            0:  begin r = (a + b) % 256; m.cout = (a + b) > 255;
                      s = sa + sb; m.ovf = (s > 127) || (s < -128); end
            1:  begin r = (a - b + 256) % 256; m.cout = a < b;
                      s = sa - sb; m.ovf = (s > 127) || (s < -128); end
            2:  r = 255 - a;
            3:  r = 255 - b;
            4:  r = a & b;
            5:  r = a | b;
            6:  r = a ^ b;
            7:  r = 255 - (a ^ b);
            8:  begin r = (a * 2) % 256; m.cout = a >= 128; end
            9:  begin r = a / 2; m.cout = (a % 2) == 1; end
            10: begin r = a / 2 + ((a >= 128) ? 128 : 0); m.cout = (a % 2) == 1; end
            11: r = a * b;
            default: begin r = 0; m.err = 1'b1; end
        endcase
        m.res  = r[15:0];
        m.zero = (r == 0);
        m.neg  = (op < 11) && (r >= 128);
        return m;
    endfunction

    function automatic fl_t obs();
        return {bus.result, bus.cout, bus.zero, bus.neg, bus.ovf, bus.err};
    endfunction

    // Drive one operation; lat = negedges after accept until done (40 = timeout).
    task automatic do_op(input int op, input int a, input int b,
                         output fl_t f, output int lat, output int bcnt,
                         output logic done_next);
        @(negedge clk);
        bus.go = 1'b1; bus.opcode = op[3:0]; bus.a = a[7:0]; bus.b = b[7:0];
        @(negedge clk);
        bus.go = 1'b0;
        lat = 0; bcnt = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        f = obs();
        @(negedge clk);
        done_next = bus.done;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (obs() !== '0) begin
            bad++; $display("FAIL reset_flags got=%h want=0", obs());
        end
        total++;
        if ({bus.busy, bus.done, bus.led_idle, bus.led_ready, bus.led_done} !== 5'b00110) begin
            bad++; $display("FAIL reset_status got=%b want=00110",
                {bus.busy, bus.done, bus.led_idle, bus.led_ready, bus.led_done});
        end
        reset = 1'b1;
    endtask

    task automatic test_add();
        fl_t f; int lat, bc; logic dn;
        do_op(0, 200, 100, f, lat, bc, dn);
        total++;
        if ({f.res, f.cout, f.ovf, f.zero} !== {16'd44, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL add_200_100 got=%h want res=002c cout=1 ovf=0 zero=0", f);
        end
        total++;
        if (lat !== 1 || dn !== 1'b0) begin
            bad++; $display("FAIL add_done_timing got lat=%0d done_next=%b want lat=1 done_next=0", lat, dn);
        end
        total++;
        if ({bus.led_done, bus.led_idle, bus.led_ready} !== 3'b101) begin
            bad++; $display("FAIL add_leds got=%b want=101", {bus.led_done, bus.led_idle, bus.led_ready});
        end
    endtask

    task automatic test_sub();
        fl_t f; int lat, bc; logic dn;
        do_op(1, 8'h80, 8'h01, f, lat, bc, dn);
        total++;
        if ({f.res, f.ovf, f.cout, f.neg} !== {16'h007F, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL sub_80_01 got=%h want res=007f ovf=1 cout=0 neg=0", f);
        end
        do_op(1, 3, 5, f, lat, bc, dn);
        total++;
        if ({f.res, f.cout, f.neg} !== {16'h00FE, 1'b1, 1'b1}) begin
            bad++; $display("FAIL sub_3_5 got=%h want res=00fe cout=1 neg=1", f);
        end
    endtask

    task automatic test_mul();
        fl_t f; int lat, bc; logic dn;
        do_op(11, 255, 255, f, lat, bc, dn);
        total++;
        if (f !== {16'hFE01, 5'b00000}) begin
            bad++; $display("FAIL mul_255_255 got=%h want res=fe01 flags=0", f);
        end
        total++;
        if (lat !== 8 || bc !== 8 || dn !== 1'b0) begin
            bad++; $display("FAIL mul_timing got lat=%0d busy=%0d done_next=%b want 8/8/0", lat, bc, dn);
        end
    endtask

    task automatic test_latch();
        int lat;
        @(negedge clk);
        bus.go = 1'b1; bus.opcode = 4'd11; bus.a = 8'd13; bus.b = 8'd11;
        @(negedge clk);
        lat = 0;
        while (!bus.done && lat < 40) begin
            bus.a      = 8'($urandom);
            bus.b      = 8'($urandom);
            bus.opcode = 4'($urandom);
            bus.go     = (lat < 6) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            lat++;
        end
        bus.go = 1'b0;
        total++;
        if (bus.result !== 16'd143 || lat !== 8) begin
            bad++; $display("FAIL latch_mul got res=%0d lat=%0d want res=143 lat=8", bus.result, lat);
        end
        @(negedge clk);
        total++;
        if ({bus.led_ready, bus.busy, bus.done} !== 3'b100) begin
            bad++; $display("FAIL latch_no_restart got=%b want=100", {bus.led_ready, bus.busy, bus.done});
        end
    endtask

    task automatic test_illegal_asr();
        fl_t f; int lat, bc; logic dn;
        do_op(13, 8'h5A, 8'hA5, f, lat, bc, dn);
        total++;
        if (f !== {16'h0000, 5'b01001}) begin
            bad++; $display("FAIL illegal_13 got=%h want res=0 zero=1 err=1 others=0", f);
        end
        do_op(10, 8'h81, 8'h00, f, lat, bc, dn);
        total++;
        if ({f.res, f.cout, f.err} !== {16'h00C0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL asr_81 got=%h want res=00c0 cout=1 err=0", f);
        end
    endtask

    task automatic test_reset_mid_mul();
        fl_t f; int lat, bc; logic dn, seen;
        @(negedge clk);
        bus.go = 1'b1; bus.opcode = 4'd11; bus.a = 8'd255; bus.b = 8'd255;
        @(negedge clk);
        bus.go = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (obs() !== '0 ||
            {bus.busy, bus.done, bus.led_idle, bus.led_ready, bus.led_done} !== 5'b00110) begin
            bad++; $display("FAIL midmul_reset got flags=%h status=%b want 0/00110", obs(),
                {bus.busy, bus.done, bus.led_idle, bus.led_ready, bus.led_done});
        end
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL midmul_no_done got done_seen=%b want=0", seen);
        end
        do_op(0, 1, 1, f, lat, bc, dn);
        total++;
        if (f.res !== 16'd2 || lat !== 1) begin
            bad++; $display("FAIL after_reset_add got res=%0d lat=%0d want res=2 lat=1", f.res, lat);
        end
    endtask

    task automatic test_random();
        fl_t f, m; int lat, bc, op, a, b; logic dn;
        int edges[5] = '{0, 255, 128, 127, 1};
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 15);
            a  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom_range(0, 255);
            b  = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 4)] : $urandom_range(0, 255);
            do_op(op, a, b, f, lat, bc, dn);
            m = model(op, a, b);
            total++;
            if (f !== m) begin
                bad++; $display("FAIL rand_op%0d a=%0d b=%0d got=%h want=%h", op, a, b, f, m);
            end
            total++;
            if (lat !== ((op == 11) ? 8 : 1) || dn !== 1'b0) begin
                bad++; $display("FAIL rand_lat op%0d got lat=%0d done_next=%b", op, lat, dn);
            end
        end
    endtask

    task automatic run_b2b(input int op, input int a, input int b,
                           output int t0, output int t1, output int t2, output fl_t f);
        int t[3] = '{-1, -1, -1};
        int n = 0, k = 0;
        @(negedge clk);
        bus.go = 1'b1; bus.opcode = op[3:0]; bus.a = a[7:0]; bus.b = b[7:0];
        while (n < 3 && k < 60) begin
            @(negedge clk);
            k++;
            if (bus.done) begin
                t[n] = cyc;
                n++;
                if (n == 3) bus.go = 1'b0;
            end
        end
        bus.go = 1'b0;
        f = obs();
        repeat (2) @(negedge clk);
        t0 = t[0]; t1 = t[1]; t2 = t[2];
    endtask

    task automatic test_back_to_back();
        int t0, t1, t2; fl_t f;
        run_b2b(0, 3, 4, t0, t1, t2, f);
        total++;
        if (t0 < 0 || t1 - t0 !== 3 || t2 - t1 !== 3 || f.res !== 16'd7) begin
            bad++; $display("FAIL b2b_add got t=%0d,%0d,%0d res=%0d want spacing 3 res=7", t0, t1, t2, f.res);
        end
        run_b2b(11, 7, 9, t0, t1, t2, f);
        total++;
        if (t0 < 0 || t1 - t0 !== 10 || t2 - t1 !== 10 || f.res !== 16'd63) begin
            bad++; $display("FAIL b2b_mul got t=%0d,%0d,%0d res=%0d want spacing 10 res=63", t0, t1, t2, f.res);
        end
        total++;
        if (bus.led_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL b2b_idle got ready=%b busy=%b want 1/0", bus.led_ready, bus.busy);
        end
    endtask

    initial begin
        bus.go = 1'b0; bus.opcode = '0; bus.a = '0; bus.b = '0;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_latch();
        test_illegal_asr();
        test_reset_mid_mul();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
